// File: rtl/fifo_pkg.sv
// Shared constants, helpers and pointer layout for the sync FIFO family.
// Optional sticky error flags are enabled by FIFO_ERR_FLAGS_EN.
package fifo_pkg;

   localparam int FIFO_DEF_WIDTH = 8;
   localparam int FIFO_DEF_DEPTH = 16;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   localparam int FIFO_DEF_AW = clog2(FIFO_DEF_DEPTH);

   // Pointer layout at the default depth: wrap bit above the storage index.
   typedef struct packed {
      logic                   wrap;
      logic [FIFO_DEF_AW-1:0] idx;
   } fifo_ptr_t;

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage with one write port and one registered read port.
// Contents and read data are cleared by rst.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int  WIDTH = FIFO_DEF_WIDTH,
   parameter int  DEPTH = FIFO_DEF_DEPTH,
   localparam int AW    = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wen,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             ren,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Read samples pre-edge contents, so a same-edge write never bypasses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         rdata <= '0;
      end else begin
         if (wen) begin
            mem[waddr] <= wdata;
         end
         if (ren) begin
            rdata <= mem[raddr];
         end
      end
   end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with count and almost flags.
// Sticky overflow/underflow are built only when FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int  WIDTH    = FIFO_DEF_WIDTH,
   parameter int  DEPTH    = FIFO_DEF_DEPTH,
   parameter int  AF_LEVEL = 14,
   parameter int  AE_LEVEL = 2,
   localparam int AW       = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             write_enable,
   input  logic             read_enable,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [AW:0]      count,
   output logic             overflow,
   output logic             underflow
);

   typedef struct packed {
      logic          wrap;
      logic [AW-1:0] idx;
   } ptr_t;

   ptr_t        wptr;
   ptr_t        rptr;
   ptr_t        wptr_next;
   ptr_t        rptr_next;
   logic        wr_acc;
   logic        rd_acc;
   logic [AW:0] count_next;

   always_comb begin
      wr_acc     = write_enable && !full;
      rd_acc     = read_enable && !empty;
      wptr_next  = ptr_t'(wptr + {{AW{1'b0}}, wr_acc});
      rptr_next  = ptr_t'(rptr + {{AW{1'b0}}, rd_acc});
      count_next = wptr_next - rptr_next;
   end

   // Flags come from next-state pointers so they are exact after the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr         <= '0;
         rptr         <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         wptr         <= wptr_next;
         rptr         <= rptr_next;
         count        <= count_next;
         full         <= (wptr_next.idx == rptr_next.idx) &&
                         (wptr_next.wrap != rptr_next.wrap);
         empty        <= (wptr_next == rptr_next);
         almost_full  <= count_next >= (AW+1)'(AF_LEVEL);
         almost_empty <= count_next <= (AW+1)'(AE_LEVEL);
      end
   end

   fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .wen   (wr_acc),
      .waddr (wptr.idx),
      .wdata (data_in),
      .ren   (rd_acc),
      .raddr (rptr.idx),
      .rdata (data_out)
   );

`ifdef FIFO_ERR_FLAGS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= overflow | (write_enable && full);
         underflow <= underflow | (read_enable && empty);
      end
   end
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param against a queue reference model.
// Error-flag expectations follow FIFO_ERR_FLAGS_EN.
module tb_sync_fifo_param;

   localparam int DEPTH = 16;
`ifdef FIFO_ERR_FLAGS_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data_in = '0;
   logic       write_enable = 1'b0;
   logic       read_enable = 1'b0;
   logic [7:0] data_out;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic [4:0] count;
   logic       overflow;
   logic       underflow;

   int checks = 0;
   int passes = 0;

   logic [7:0] q[$];
   logic [7:0] m_dout = '0;
   bit         m_ovf = 1'b0;
   bit         m_udf = 1'b0;

   always #5 clk = ~clk;

   sync_fifo_param dut (
      .clk          (clk),
      .rst          (rst),
      .data_in      (data_in),
      .write_enable (write_enable),
      .read_enable  (read_enable),
      .data_out     (data_out),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   function automatic bit exp_ovf();
      return ERR_EN && m_ovf;
   endfunction

   function automatic bit exp_udf();
      return ERR_EN && m_udf;
   endfunction

   task automatic model_reset();
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
   endtask

   // One clock of stimulus; model follows the FIFO rules at queue level.
   task automatic drive(input bit we, input bit re, input logic [7:0] d);
      bit f;
      bit e;
      f = (q.size() == DEPTH);
      e = (q.size() == 0);
      write_enable = we;
      read_enable  = re;
      data_in      = d;
      if (we && f) m_ovf = 1'b1;
      if (re && e) m_udf = 1'b1;
      if (re && !e) m_dout = q.pop_front();
      if (we && !f) q.push_back(d);
      @(posedge clk);
      #1;
      write_enable = 1'b0;
      read_enable  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #6 rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({empty, almost_empty, full, almost_full} !== 4'b1100)
         $display("FAIL reset_flags: got %b want 1100",
                  {empty, almost_empty, full, almost_full});
      else passes++;
      checks++;
      if (count !== 5'd0 || data_out !== 8'h00)
         $display("FAIL reset_count_dout: got %0d/%h want 0/00",
                  count, data_out);
      else passes++;
      for (int i = 0; i < 5; i++) drive(1, 0, 8'hC0 + 8'(i));
      drive(0, 1, 8'h00);
      drive(1, 0, 8'hC5);
      checks++;
      if (count !== 5'd5)
         $display("FAIL pre_reset_count: got %0d want 5", count);
      else passes++;
      #2 rst = 1'b1;
      #1;
      model_reset();
      checks++;
      if ({empty, almost_empty, full, almost_full} !== 4'b1100)
         $display("FAIL midrst_flags: got %b want 1100",
                  {empty, almost_empty, full, almost_full});
      else passes++;
      checks++;
      if (count !== 5'd0 || data_out !== 8'h00)
         $display("FAIL midrst_count_dout: got %0d/%h want 0/00",
                  count, data_out);
      else passes++;
      checks++;
      if (overflow !== 1'b0 || underflow !== 1'b0)
         $display("FAIL midrst_err: got %b%b want 00", overflow, underflow);
      else passes++;
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_fill();
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 0, 8'(i));
         checks++;
         if (count !== 5'(i + 1))
            $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1);
         else passes++;
         checks++;
         if (almost_full !== (i + 1 >= 14) || full !== (i + 1 == DEPTH))
            $display("FAIL fill_flags[%0d]: got af=%b f=%b want af=%b f=%b",
                     i, almost_full, full, (i + 1 >= 14), (i + 1 == DEPTH));
         else passes++;
      end
      drive(1, 0, 8'hAA);
      checks++;
      if (count !== 5'd16 || full !== 1'b1)
         $display("FAIL overrun_count: got %0d f=%b want 16 f=1", count, full);
      else passes++;
      checks++;
      if (overflow !== exp_ovf())
         $display("FAIL overflow: got %b want %b", overflow, exp_ovf());
      else passes++;
   endtask

   task automatic test_drain();
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 1, 8'h00);
         checks++;
         if (data_out !== 8'(i))
            $display("FAIL drain_data[%0d]: got %h want %h", i, data_out, 8'(i));
         else passes++;
         checks++;
         if (almost_empty !== (DEPTH - 1 - i <= 2) ||
             empty !== (i == DEPTH - 1))
            $display("FAIL drain_flags[%0d]: got ae=%b e=%b want ae=%b e=%b",
                     i, almost_empty, empty, (DEPTH - 1 - i <= 2),
                     (i == DEPTH - 1));
         else passes++;
      end
      drive(0, 1, 8'h00);
      checks++;
      if (data_out !== 8'h0F || count !== 5'd0)
         $display("FAIL underrun_dout: got %h/%0d want 0f/0", data_out, count);
      else passes++;
      checks++;
      if (underflow !== exp_udf())
         $display("FAIL underflow: got %b want %b", underflow, exp_udf());
      else passes++;
   endtask

   task automatic test_wrap();
      logic [7:0] d;
      for (int i = 0; i < 40; i++) begin
         d = 8'($urandom);
         drive(1, 0, d);
         checks++;
         if (count !== 5'd1 || full !== 1'b0)
            $display("FAIL wrap_wr[%0d]: got c=%0d f=%b want c=1 f=0",
                     i, count, full);
         else passes++;
         drive(0, 1, 8'h00);
         checks++;
         if (data_out !== d || count !== 5'd0 || full !== 1'b0)
            $display("FAIL wrap_rd[%0d]: got %h c=%0d want %h c=0",
                     i, data_out, count, d);
         else passes++;
      end
   endtask

   task automatic test_simultaneous();
      logic [7:0] oldest;
      for (int i = 0; i < 8; i++) drive(1, 0, 8'($urandom));
      oldest = q[0];
      drive(1, 1, 8'h55);
      checks++;
      if (count !== 5'd8 || data_out !== oldest)
         $display("FAIL simul8: got c=%0d %h want c=8 %h",
                  count, data_out, oldest);
      else passes++;
      while (q.size() < DEPTH) drive(1, 0, 8'($urandom));
      checks++;
      if (full !== 1'b1)
         $display("FAIL simul_full: got %b want 1", full);
      else passes++;
      oldest = q[0];
      drive(1, 1, 8'h77);
      checks++;
      if (count !== 5'd15 || data_out !== oldest || full !== 1'b0)
         $display("FAIL simul_full_rw: got c=%0d %h f=%b want c=15 %h f=0",
                  count, data_out, full, oldest);
      else passes++;
      checks++;
      if (overflow !== exp_ovf())
         $display("FAIL simul_ovf: got %b want %b", overflow, exp_ovf());
      else passes++;
   endtask

   task automatic test_random();
      int n;
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
               8'($urandom));
         n = q.size();
         checks++;
         if (data_out !== m_dout || count !== 5'(n))
            $display("FAIL rnd_data[%0d]: got %h c=%0d want %h c=%0d",
                     i, data_out, count, m_dout, n);
         else passes++;
         checks++;
         if ({full, empty, almost_full, almost_empty} !==
             {(n == DEPTH), (n == 0), (n >= 14), (n <= 2)})
            $display("FAIL rnd_flags[%0d]: got %b want %b", i,
                     {full, empty, almost_full, almost_empty},
                     {(n == DEPTH), (n == 0), (n >= 14), (n <= 2)});
         else passes++;
         checks++;
         if (overflow !== exp_ovf() || underflow !== exp_udf())
            $display("FAIL rnd_err[%0d]: got %b%b want %b%b", i,
                     overflow, underflow, exp_ovf(), exp_udf());
         else passes++;
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_wrap();
      test_simultaneous();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
